ram_bus_bridge: RTL and testbench

Bridges the RISC-V core's native valid/ready memory port to the single-port synchronous RAM (`ram1port`), which has one-cycle read latency and byte enables. The bridge:
- decodes a parameterised address window;
- converts byte addresses to word addresses;
- sequences read and write strobes;
- returns read data with a single-cycle `mem_ready` pulse;
- flags accesses outside the window.

It sits between the core and `ram1port`.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/ram_bus_bridge_if.sv | 21 ++
 rtl/mem_addr_decode.sv | 20 ++
 rtl/ram_bus_bridge.sv | 103 ++++++++++
 tb/tb_ram_bus_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the core-to-memory bridges.
package riscv_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  WSTRB_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } mem_state_e;

    // Byte size of a window addressed by an aw-bit word address.
    function automatic logic [31:0] window_bytes(input int unsigned aw);
        return 32'(WORD_BYTES) << aw;
    endfunction

endpackage

// File: rtl/ram_bus_bridge_if.sv
// Core-side native valid/ready memory port.
interface ram_bus_bridge_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_addr_decode.sv
// Window hit detection and byte-to-word address extraction for a memory bridge.
module mem_addr_decode #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] word_addr
);

    localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

    // Byte lane bits never reach the RAM.
    logic unused_lsbs;

    assign hit         = (addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign word_addr   = addr[ADDR_WIDTH+1:2];
    assign unused_lsbs = ^addr[1:0];

endmodule

// File: rtl/ram_bus_bridge.sv
// Bridges the core valid/ready memory port to a single-port synchronous RAM
// with one-cycle read latency, and records out-of-window accesses.
module ram_bus_bridge
    import riscv_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    ram_bus_bridge_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [3:0]            ram_byteena,
    output logic [31:0]           ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [31:0]           ram_q,
    input  logic                  err_clear,
    output logic                  bus_error,
    output logic [31:0]           bus_err_addr
);

    mem_state_e state;
    logic       hit;
    logic       idle_req;
    logic       req_wr;
    logic       req_rd;
    logic       req_fault;

    mem_addr_decode #(
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .addr      (bus.mem_addr),
        .hit       (hit),
        .word_addr (ram_address)
    );

    assign ram_data    = bus.mem_wdata;
    assign ram_byteena = bus.mem_wstrb;

    // A request is only accepted from IDLE; anything seen in RD_WAIT/ACK is ignored.
    always_comb begin
        idle_req  = (state == IDLE) && bus.mem_valid;
        req_wr    = idle_req && hit && (bus.mem_wstrb != WSTRB_NONE);
        req_rd    = idle_req && hit && (bus.mem_wstrb == WSTRB_NONE);
        req_fault = idle_req && !hit;
    end

    assign ram_wren = req_wr && resetn;
    assign ram_rden = req_rd && resetn;

    // Sequencer, read-data register and sticky error capture.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            bus_error     <= 1'b0;
            bus_err_addr  <= '0;
        end else begin
            bus.mem_ready <= 1'b0;

            if (err_clear) begin
                bus_error <= 1'b0;
            end
            // A fault colliding with a clear wins and re-arms the address capture.
            if (req_fault) begin
                bus_error <= 1'b1;
                if (!bus_error || err_clear) begin
                    bus_err_addr <= bus.mem_addr;
                end
            end

            case (state)
                IDLE: begin
                    if (req_wr) begin
                        state         <= ACK;
                        bus.mem_ready <= 1'b1;
                    end else if (req_rd) begin
                        state <= RD_WAIT;
                    end else if (req_fault) begin
                        state         <= ACK;
                        bus.mem_ready <= 1'b1;
                        bus.mem_rdata <= '0;
                    end
                end
                RD_WAIT: begin
                    bus.mem_rdata <= ram_q;
                    bus.mem_ready <= 1'b1;
                    state         <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Self-checking bench for ram_bus_bridge with a behavioural RAM and reference memory model.
module tb_ram_bus_bridge;

    localparam int unsigned AW     = 8;
    localparam int unsigned NWORDS = 1 << AW;
    localparam logic [31:0] WIN    = 32'(4) << AW;

    logic          clock;
    logic          resetn;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_byteena;
    logic [31:0]   ram_data;
    logic          ram_rden;
    logic          ram_wren;
    logic [31:0]   ram_q;
    logic          err_clear;
    logic          bus_error;
    logic [31:0]   bus_err_addr;

    ram_bus_bridge_if bus ();

    ram_bus_bridge #(
        .BASE_ADDR  (32'h0000_0000),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .bus          (bus),
        .ram_address  (ram_address),
        .ram_byteena  (ram_byteena),
        .ram_data     (ram_data),
        .ram_rden     (ram_rden),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .err_clear    (err_clear),
        .bus_error    (bus_error),
        .bus_err_addr (bus_err_addr)
    );

    int tests  = 0;
    int failed = 0;

    // Environment RAM: one-cycle read latency, byte enables, not reset.
    logic [31:0] ram_arr [NWORDS];
    always @(posedge clock) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteena[b]) ram_arr[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
        end
        if (ram_rden) ram_q <= ram_arr[ram_address];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state.
    logic [31:0] ref_mem [NWORDS];
    logic        ref_err;
    logic [31:0] ref_err_addr;

    // Observations of one transfer.
    logic [31:0] o_rdata;
    int          o_lat;
    logic        o_rd0, o_wr0, o_bad, o_extra;
    logic [AW-1:0] o_addr0;

    function automatic bit in_window(input logic [31:0] a);
        return (a < WIN);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % NWORDS);
    endfunction

    // Model update for one completed access (plain arithmetic on the spec rules).
    task automatic model_access(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic clr);
        if (!in_window(a)) begin
            if (!ref_err || clr) ref_err_addr = a;
            ref_err = 1'b1;
        end else begin
            if (clr) ref_err = 1'b0;
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Drives one request starting in an IDLE cycle; returns in the IDLE cycle after the ready.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic clr);
        bit done;
        done          = 0;
        o_bad         = 0;
        o_extra       = 0;
        o_lat         = 99;
        o_rdata       = 'x;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = s;
        err_clear     = clr;
        #1;
        o_rd0   = ram_rden;
        o_wr0   = ram_wren;
        o_addr0 = ram_address;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(posedge clock); #1;
            err_clear = 1'b0;
            if (ram_rden || ram_wren) o_bad = 1;
            if (bus.mem_ready) begin
                o_lat   = c;
                o_rdata = bus.mem_rdata;
                done    = 1;
            end
        end
        bus.mem_valid = 1'b0;
        @(posedge clock); #1;
        if (bus.mem_ready) o_extra = 1;
    endtask

    task automatic test_reset;
        resetn        = 1'b1;
        err_clear     = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        ram_q         = '0;
        for (int i = 0; i < int'(NWORDS); i++) begin
            ram_arr[i] = '0;
            ref_mem[i] = '0;
        end
        ref_err      = 1'b0;
        ref_err_addr = '0;
        #1 resetn = 1'b0;
        bus.mem_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
            failed++;
            $display("FAIL reset_outputs ready=%b rdata=%h required 0/00000000", bus.mem_ready, bus.mem_rdata);
        end
        tests++;
        if (bus_error !== 1'b0 || bus_err_addr !== 32'h0) begin
            failed++;
            $display("FAIL reset_error err=%b addr=%h required 0/00000000", bus_error, bus_err_addr);
        end
        tests++;
        if (ram_rden !== 1'b0 || ram_wren !== 1'b0) begin
            failed++;
            $display("FAIL reset_strobes rden=%b wren=%b required 0/0", ram_rden, ram_wren);
        end
        bus.mem_valid = 1'b0;
        resetn        = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_write_read;
        xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        model_access(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        tests++;
        if (o_lat !== 1 || o_wr0 !== 1'b1 || o_rd0 !== 1'b0 || o_addr0 !== AW'(4)) begin
            failed++;
            $display("FAIL wr_word lat=%0d wr=%b rd=%b addr=%0d required 1/1/0/4", o_lat, o_wr0, o_rd0, o_addr0);
        end
        xfer(32'h10, 32'h0, 4'h0, 1'b0);
        tests++;
        if (o_lat !== 2 || o_rdata !== 32'hDEADBEEF || o_rd0 !== 1'b1 || o_addr0 !== AW'(4)) begin
            failed++;
            $display("FAIL rd_word lat=%0d rdata=%h rd=%b addr=%0d required 2/deadbeef/1/4", o_lat, o_rdata, o_rd0, o_addr0);
        end
    endtask

    task automatic test_byte_enable;
        xfer(32'h20, 32'h11223344, 4'hF, 1'b0);
        model_access(32'h20, 32'h11223344, 4'hF, 1'b0);
        xfer(32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
        model_access(32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
        xfer(32'h20, 32'h0, 4'h0, 1'b0);
        tests++;
        if (o_rdata !== 32'h11BB33DD || o_lat !== 2) begin
            failed++;
            $display("FAIL byte_en rdata=%h lat=%0d required 11bb33dd/2", o_rdata, o_lat);
        end
    endtask

    task automatic test_out_of_window;
        xfer(32'h0000_0400, 32'h0, 4'h0, 1'b0);
        model_access(32'h0000_0400, 32'h0, 4'h0, 1'b0);
        tests++;
        if (o_rd0 !== 1'b0 || o_wr0 !== 1'b0 || o_lat !== 1 || o_rdata !== 32'h0) begin
            failed++;
            $display("FAIL oob_read rd=%b wr=%b lat=%0d rdata=%h required 0/0/1/00000000", o_rd0, o_wr0, o_lat, o_rdata);
        end
        tests++;
        if (bus_error !== 1'b1 || bus_err_addr !== 32'h400) begin
            failed++;
            $display("FAIL oob_capture err=%b addr=%h required 1/00000400", bus_error, bus_err_addr);
        end
        xfer(32'h0000_0800, 32'h5, 4'h3, 1'b0);
        model_access(32'h0000_0800, 32'h5, 4'h3, 1'b0);
        tests++;
        if (bus_error !== 1'b1 || bus_err_addr !== 32'h400 || o_wr0 !== 1'b0) begin
            failed++;
            $display("FAIL oob_sticky err=%b addr=%h wr=%b required 1/00000400/0", bus_error, bus_err_addr, o_wr0);
        end
    endtask

    task automatic test_clear_collision;
        xfer(32'h0000_0900, 32'h0, 4'h0, 1'b1);
        model_access(32'h0000_0900, 32'h0, 4'h0, 1'b1);
        tests++;
        if (bus_error !== 1'b1 || bus_err_addr !== 32'h900) begin
            failed++;
            $display("FAIL clr_collide err=%b addr=%h required 1/00000900", bus_error, bus_err_addr);
        end
        err_clear = 1'b1;
        @(posedge clock); #1;
        err_clear = 1'b0;
        ref_err   = 1'b0;
        tests++;
        if (bus_error !== 1'b0 || bus_err_addr !== 32'h900) begin
            failed++;
            $display("FAIL clr_only err=%b addr=%h required 0/00000900", bus_error, bus_err_addr);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a0, a1, d1;
        int lat0, lat1, lat2;
        logic bad;
        logic [31:0] r0, r2;
        a0 = 32'h40;
        a1 = 32'h44;
        d1 = 32'hCAFE_F00D;
        bad = 0;
        xfer(a0, 32'h0, 4'h0, 1'b0);
        lat0 = o_lat; r0 = o_rdata; bad = bad | o_bad | o_extra;
        xfer(a1, d1, 4'hF, 1'b0);
        model_access(a1, d1, 4'hF, 1'b0);
        lat1 = o_lat; bad = bad | o_bad | o_extra;
        xfer(a1, 32'h0, 4'h0, 1'b0);
        lat2 = o_lat; r2 = o_rdata; bad = bad | o_bad | o_extra;
        tests++;
        if (lat0 != 2 || lat1 != 1 || lat2 != 2) begin
            failed++;
            $display("FAIL b2b_latency lat=%0d/%0d/%0d required 2/1/2", lat0, lat1, lat2);
        end
        tests++;
        if (bad !== 1'b0) begin
            failed++;
            $display("FAIL b2b_strobes extra strobe or ready seen=%b required 0", bad);
        end
        tests++;
        if (r0 !== ref_mem[widx(a0)] || r2 !== d1) begin
            failed++;
            $display("FAIL b2b_data rdata=%h/%h required %h/%h", r0, r2, ref_mem[widx(a0)], d1);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, d, exp_rd;
        logic [3:0]  s;
        logic        clr;
        int          exp_lat;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, NWORDS - 1)) * 4 + 32'($urandom_range(0, 3));
            else a = $urandom | WIN;
            d   = $urandom;
            s   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            clr = ($urandom_range(0, 7) == 0);
            exp_rd  = in_window(a) ? ref_mem[widx(a)] : 32'h0;
            exp_lat = (in_window(a) && s == 4'h0) ? 2 : 1;
            xfer(a, d, s, clr);
            model_access(a, d, s, clr);
            tests++;
            if (o_lat != exp_lat || o_bad || o_extra) begin
                failed++;
                $display("FAIL rnd_timing n=%0d addr=%h lat=%0d bad=%b extra=%b required lat %0d", n, a, o_lat, o_bad, o_extra, exp_lat);
            end
            if (s == 4'h0) begin
                tests++;
                if (o_rdata !== exp_rd) begin
                    failed++;
                    $display("FAIL rnd_rdata n=%0d addr=%h got=%h required %h", n, a, o_rdata, exp_rd);
                end
            end
            tests++;
            if (bus_error !== ref_err || (ref_err && bus_err_addr !== ref_err_addr)) begin
                failed++;
                $display("FAIL rnd_error n=%0d err=%b addr=%h required %b/%h", n, bus_error, bus_err_addr, ref_err, ref_err_addr);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        xfer(32'h10, 32'h600D_F00D, 4'hF, 1'b0);
        model_access(32'h10, 32'h600D_F00D, 4'hF, 1'b0);
        xfer(32'h10, 32'h0, 4'h0, 1'b0);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h10;
        bus.mem_wstrb = 4'h0;
        @(posedge clock); #2;
        resetn = 1'b0;
        #1;
        ref_err = 1'b0;
        tests++;
        if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
            failed++;
            $display("FAIL rst_mid_read ready=%b rdata=%h required 0/00000000", bus.mem_ready, bus.mem_rdata);
        end
        @(posedge clock); #1;
        tests++;
        if (ram_rden !== 1'b0 || bus.mem_ready !== 1'b0) begin
            failed++;
            $display("FAIL rst_held rden=%b ready=%b required 0/0", ram_rden, bus.mem_ready);
        end
        bus.mem_valid = 1'b0;
        resetn        = 1'b1;
        @(posedge clock); #1;
        xfer(32'h10, 32'h0, 4'h0, 1'b0);
        tests++;
        if (o_lat != 2 || o_rdata !== 32'h600D_F00D) begin
            failed++;
            $display("FAIL rst_recover lat=%0d rdata=%h required 2/600df00d", o_lat, o_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_out_of_window();
        test_clear_collision();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
